instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline. Holds the PC and an internal instruction memory,
//  and drives the IF/ID register (o_instruction, o_pcounter4) that instruction_decode consumes.
//  Handles stall, jump/branch redirect with flush, program loading while idle, and halt detection.
// PARAMETERS
//  NB_DATA   32  instruction / PC width
//  NB_ADDR   8   instruction memory word-address width (depth = 2**NB_ADDR words)
//  RESET_PC  0   PC value after reset
//  HALT_WORD 32'hFFFF_FFFF  encoding that halts fetch
// PORTS
//  clk            in   1        rising-edge clock
//  i_rst          in   1        asynchronous reset, active-high
//  i_start        in   1        IDLE -> RUN request
//  i_we_imem      in   1        program-load write strobe (honoured only in IDLE)
//  i_imem_addr    in   NB_ADDR  program-load word address
//  i_imem_data    in   NB_DATA  program-load word
//  i_stall        in   1        hold PC and IF/ID (hazard unit)
//  i_jump         in   1        jump redirect, target i_jump_addr
//  i_jump_addr    in   NB_DATA  jump target (byte address)
//  i_branch       in   1        taken-branch redirect, target i_branch_addr
//  i_branch_addr  in   NB_DATA  branch target (byte address)
//  o_instruction  out  NB_DATA  IF/ID instruction (0 = NOP)
//  o_pcounter4    out  NB_DATA  IF/ID PC+4 of o_instruction
//  o_pcounter     out  NB_DATA  current fetch PC
//  o_halt         out  1        high while in HALT
// BEHAVIOUR
//  Reset (async, i_rst=1): state=IDLE, PC=RESET_PC, o_instruction=0, o_pcounter4=0, o_halt=0.
//   Memory contents are NOT cleared by reset. Reset mid-RUN aborts immediately.
//  Fetch index = PC[NB_ADDR+1:2]; PC bits [1:0] ignored; PC beyond depth wraps modulo depth.
//  Memory read is combinational; IF/ID is registered -> instruction at PC appears on
//   o_instruction 1 cycle after PC presents it; o_pcounter4 = PC+4 (mod 2**NB_DATA).
//  FSM:
//   IDLE: PC held at RESET_PC, IF/ID = NOP. i_we_imem writes imem[i_imem_addr] at the edge.
//         i_start=1 -> RUN next cycle (simultaneous write still lands). i_stall/i_jump/i_branch ignored.
//   RUN : per edge, priority order:
//         1. i_jump: PC<=i_jump_addr, IF/ID<=NOP (flush, o_pcounter4<=0). Wins over i_branch.
//         2. i_branch: PC<=i_branch_addr, IF/ID<=NOP.
//         3. i_stall: PC and IF/ID hold.
//         4. else: IF/ID<=imem[PC], PC<=PC+4; if fetched word==HALT_WORD -> HALT,
//            halt word is latched into IF/ID, PC stays at the halt address.
//         Redirect outranks stall. A halt word fetched in a redirect cycle is flushed, no HALT.
//         i_we_imem and i_start are ignored in RUN.
//   HALT: o_halt=1, PC frozen; IF/ID loads NOP from the next edge on, so the pipeline drains.
//         All inputs are ignored. Only reset exits.
//  o_pcounter = PC register (registered, no combinational path from inputs).
// TESTING
//  1 Reset: assert i_rst mid-RUN at PC=0x10 -> same cycle PC=0, o_instruction=0, o_halt=0;
//    reload-free restart (i_start) fetches the previous program from word 0.
//  2 Load {0x00221820, 0x20220004, 0xFFFFFFFF} in IDLE, i_start -> o_instruction 0x00221820
//    with o_pcounter4=4, then 0x20220004/8, then 0xFFFFFFFF/12 with o_halt=1; NOPs afterwards.
//  3 Stall: i_stall high for 3 cycles during RUN at PC=4 -> o_instruction and o_pcounter stay
//    constant for 3 cycles, then the sequence resumes with no skipped or repeated word.
//  4 Redirect: i_jump=1 with i_jump_addr=0x40 plus i_stall=1 -> next cycle o_instruction=0,
//    PC=0x40; following cycle o_instruction=imem[16], o_pcounter4=0x44.
//  5 Jump+branch together (jump 0x20, branch 0x30) -> PC=0x20. Branch to 0x400 with NB_ADDR=8
//    -> fetch wraps to imem[0].
//  6 i_we_imem during RUN to addr 0 -> imem[0] unchanged; halt word fetched alongside i_branch
//    -> no HALT, PC=branch target.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program load, hazard/redirect controls in, IF/ID register and status out.
interface instruction_fetch_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               i_start;
  logic               i_we_imem;
  logic [NB_ADDR-1:0] i_imem_addr;
  logic [NB_DATA-1:0] i_imem_data;
  logic               i_stall;
  logic               i_jump;
  logic [NB_DATA-1:0] i_jump_addr;
  logic               i_branch;
  logic [NB_DATA-1:0] i_branch_addr;
  logic [NB_DATA-1:0] o_instruction;
  logic [NB_DATA-1:0] o_pcounter4;
  logic [NB_DATA-1:0] o_pcounter;
  logic               o_halt;

  modport slave (
    input  i_start, i_we_imem, i_imem_addr, i_imem_data, i_stall,
           i_jump, i_jump_addr, i_branch, i_branch_addr,
    output o_instruction, o_pcounter4, o_pcounter, o_halt
  );

  modport master (
    output i_start, i_we_imem, i_imem_addr, i_imem_data, i_stall,
           i_jump, i_jump_addr, i_branch, i_branch_addr,
    input  o_instruction, o_pcounter4, o_pcounter, o_halt
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, word-addressed instruction memory, IF/ID register, and IDLE/RUN/HALT control.
module instruction_fetch #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] RESET_PC  = '0,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic                clk,
  input logic                i_rst,
  instruction_fetch_if.slave bus
);
  localparam int DEPTH = 2 ** NB_ADDR;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic               halt_q, halt_d;
  logic [NB_DATA-1:0] fetch_word;

  logic [NB_DATA-1:0] imem [DEPTH];

  // Byte PC -> word index; upper bits drop out so fetch wraps modulo depth.
  assign fetch_word = imem[pc_q[NB_ADDR+1:2]];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    halt_d  = halt_q;
    case (state_q)
      S_IDLE: begin
        pc_d    = RESET_PC;
        instr_d = '0;
        pc4_d   = '0;
        if (bus.i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.i_jump) begin
          pc_d    = bus.i_jump_addr;
          instr_d = '0;
          pc4_d   = '0;
        end else if (bus.i_branch) begin
          pc_d    = bus.i_branch_addr;
          instr_d = '0;
          pc4_d   = '0;
        end else if (!bus.i_stall) begin
          instr_d = fetch_word;
          pc4_d   = pc_q + NB_DATA'(4);
          // Halt word still goes down the pipe; PC parks on it.
          if (fetch_word == HALT_WORD) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end else begin
            pc_d = pc_q + NB_DATA'(4);
          end
        end
      end
      S_HALT: begin
        instr_d = '0;
        pc4_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      halt_q  <= halt_d;
    end
  end

  // Program store survives reset so a restart can rerun the loaded program.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.i_we_imem) imem[bus.i_imem_addr] <= bus.i_imem_data;
  end

  assign bus.o_instruction = instr_q;
  assign bus.o_pcounter4   = pc4_q;
  assign bus.o_pcounter    = pc_q;
  assign bus.o_halt        = halt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized bench for instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.NB_DATA(32), .NB_ADDR(8)) bus ();

  instruction_fetch #(.NB_DATA(32), .NB_ADDR(8), .RESET_PC(32'h0), .HALT_WORD(HALT)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = loading, 1 = fetching, 2 = stopped
  int          m_mode;
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_halt;
  logic [31:0] m_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc",    bus.o_pcounter,    m_pc);
    chk("ins",   bus.o_instruction, m_ins);
    chk("pc4",   bus.o_pcounter4,   m_pc4);
    chk("halt",  {31'b0, bus.o_halt}, {31'b0, m_halt});
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ins = 0; m_pc4 = 0; m_halt = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (m_mode == 0) begin
      if (bus.i_we_imem) m_mem[bus.i_imem_addr] = bus.i_imem_data;
      m_pc = 0; m_ins = 0; m_pc4 = 0;
      if (bus.i_start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.i_jump) begin
        m_pc = bus.i_jump_addr; m_ins = 0; m_pc4 = 0;
      end else if (bus.i_branch) begin
        m_pc = bus.i_branch_addr; m_ins = 0; m_pc4 = 0;
      end else if (!bus.i_stall) begin
        w = m_mem[(m_pc / 4) % 256];
        m_ins = w;
        m_pc4 = m_pc + 4;
        if (w == HALT) begin
          m_mode = 2; m_halt = 1;
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end else begin
      m_ins = 0; m_pc4 = 0;
    end
  endtask

  task automatic clr();
    bus.i_start = 0; bus.i_we_imem = 0; bus.i_imem_addr = 0; bus.i_imem_data = 0;
    bus.i_stall = 0; bus.i_jump = 0; bus.i_jump_addr = 0; bus.i_branch = 0; bus.i_branch_addr = 0;
  endtask

  // Called at posedge+1; leaves at posedge+1 with model and DUT compared.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    #3;
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    clr();
    bus.i_we_imem = 1; bus.i_imem_addr = a; bus.i_imem_data = d;
    tick();
    clr();
  endtask

  initial begin
    logic [31:0] d;
    int r;
    clr();
    for (int k = 0; k < 256; k++) m_mem[k] = 0;
    #2;
    do_reset();

    // Fill memory with non-halt words, one halt word at index 20, program at 0..2.
    for (int k = 0; k < 256; k++) begin
      d = $urandom;
      if (d == HALT) d = 32'h1234_5678;
      if (k == 20) d = HALT;
      load(8'(k), d);
    end
    load(8'd0, 32'h0022_1820);
    load(8'd1, 32'h2022_0004);
    load(8'd2, HALT);

    // Program runs to halt, then drains NOPs
    bus.i_start = 1; tick(); clr();
    tick(); chk("t2_ins0", bus.o_instruction, 32'h0022_1820); chk("t2_pc4_0", bus.o_pcounter4, 32'd4);
    tick(); chk("t2_ins1", bus.o_instruction, 32'h2022_0004); chk("t2_pc4_1", bus.o_pcounter4, 32'd8);
    tick(); chk("t2_ins2", bus.o_instruction, HALT); chk("t2_pc4_2", bus.o_pcounter4, 32'd12);
    chk("t2_halt", {31'b0, bus.o_halt}, 32'd1);
    bus.i_jump = 1; bus.i_jump_addr = 32'h80; bus.i_start = 1;
    tick(); clr();
    chk("t2_nop", bus.o_instruction, 32'd0); chk("t2_pcfrz", bus.o_pcounter, 32'd8);
    tick();

    // Reset mid-run at PC 0x10, then restart without reload
    do_reset();
    load(8'd2, 32'h0123_4567);
    bus.i_start = 1; tick(); clr();
    repeat (4) tick();
    chk("t1_pc10", bus.o_pcounter, 32'h10);
    rst = 1'b1; model_reset(); #1;
    chk("t1_rpc", bus.o_pcounter, 32'd0); chk("t1_rins", bus.o_instruction, 32'd0);
    chk("t1_rhalt", {31'b0, bus.o_halt}, 32'd0);
    #2; rst = 1'b0;
    bus.i_start = 1; tick(); clr();
    tick(); chk("t1_restart", bus.o_instruction, 32'h0022_1820);

    // Stall at PC 4 for three cycles
    bus.i_stall = 1;
    repeat (3) begin
      tick();
      chk("t3_ins", bus.o_instruction, 32'h0022_1820); chk("t3_pc", bus.o_pcounter, 32'd4);
    end
    clr();
    tick(); chk("t3_resume", bus.o_instruction, 32'h2022_0004); chk("t3_pc4", bus.o_pcounter4, 32'd8);

    // Jump outranks stall
    bus.i_jump = 1; bus.i_jump_addr = 32'h40; bus.i_stall = 1;
    tick(); clr();
    chk("t4_flush", bus.o_instruction, 32'd0); chk("t4_pc", bus.o_pcounter, 32'h40);
    tick(); chk("t4_ins16", bus.o_instruction, m_mem[16]); chk("t4_pc4", bus.o_pcounter4, 32'h44);

    // Jump beats branch; branch beyond depth wraps
    bus.i_jump = 1; bus.i_jump_addr = 32'h20; bus.i_branch = 1; bus.i_branch_addr = 32'h30;
    tick(); clr(); chk("t5_jwin", bus.o_pcounter, 32'h20);
    bus.i_branch = 1; bus.i_branch_addr = 32'h400;
    tick(); clr(); chk("t5_bpc", bus.o_pcounter, 32'h400);
    tick(); chk("t5_wrap", bus.o_instruction, 32'h0022_1820); chk("t5_wpc4", bus.o_pcounter4, 32'h404);

    // Writes ignored in RUN; halt word under a branch is flushed
    bus.i_we_imem = 1; bus.i_imem_addr = 0; bus.i_imem_data = 32'hDEAD_BEEF;
    tick(); clr();
    bus.i_jump = 1; bus.i_jump_addr = 0; tick(); clr();
    tick(); chk("t6_nowrite", bus.o_instruction, 32'h0022_1820);
    bus.i_jump = 1; bus.i_jump_addr = 32'h50; tick(); clr();
    bus.i_branch = 1; bus.i_branch_addr = 32'h60; tick(); clr();
    chk("t6_nohalt", {31'b0, bus.o_halt}, 32'd0); chk("t6_bpc", bus.o_pcounter, 32'h60);
    tick();

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      clr();
      r = int'($urandom_range(0, 99));
      if (r < 1 || (m_mode == 2 && r < 15)) begin
        do_reset();
      end else begin
        bus.i_we_imem     = ($urandom_range(0, 3) == 0);
        bus.i_imem_addr   = 8'($urandom);
        bus.i_imem_data   = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
        bus.i_start       = ($urandom_range(0, 4) == 0);
        bus.i_stall       = ($urandom_range(0, 4) == 0);
        bus.i_jump        = ($urandom_range(0, 19) == 0);
        bus.i_jump_addr   = $urandom;
        bus.i_branch      = ($urandom_range(0, 11) == 0);
        bus.i_branch_addr = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
